// File: rtl/decode_3_8_hold.sv
// Registered 3-to-8 decoder with valid/ready intake and a fixed output hold time.
// Define DECODE_ACT_LOW_EN to make out_1 one-cold (active-low, idle all-ones).
//
// state  | meaning
// S_IDLE | no code held; out_1 at idle value, ready for a code
// S_HOLD | decoded code driven on out_1; r_cnt counts the hold cycles
module decode_3_8_hold #(
  parameter int DATA_LEN    = 3,
  parameter int OUT_LEN     = 1 << DATA_LEN,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] in_1,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_LEN-1:0]  out_1,
  output logic                out_valid,
  output logic                busy
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [OUT_LEN-1:0] ONE    = OUT_LEN'(1);
`ifdef DECODE_ACT_LOW_EN
  localparam logic [OUT_LEN-1:0] IDLE_VAL = '1;
`else
  localparam logic [OUT_LEN-1:0] IDLE_VAL = '0;
`endif

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [OUT_LEN-1:0] r_out, w_out_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_rst_done;
  logic [OUT_LEN-1:0] w_decoded;
  logic               w_last;
  logic               w_accept;

  // r_rst_done keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_out      <= IDLE_VAL;
      r_valid    <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_out      <= w_out_nxt;
      r_valid    <= w_valid_nxt;
      r_rst_done <= 1'b1;
    end
  end

  always_comb begin
`ifdef DECODE_ACT_LOW_EN
    w_decoded = ~(ONE << in_1);
`else
    w_decoded = ONE << in_1;
`endif
    w_last      = (r_state == S_HOLD) && (r_cnt == CNT_LAST);
    in_ready    = r_rst_done && ((r_state == S_IDLE) || w_last);
    w_accept    = in_valid && in_ready;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_out_nxt   = w_decoded;
          w_valid_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (!w_last) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_accept) begin
          w_cnt_nxt = '0;
          w_out_nxt = w_decoded;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_out_nxt   = IDLE_VAL;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_out_nxt   = IDLE_VAL;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign out_1     = r_out;
  assign out_valid = r_valid;
  assign busy      = (r_state == S_HOLD);

endmodule

// File: tb/tb_decode_3_8_hold.sv
// Directed testbench for decode_3_8_hold: HOLD_CYCLES=4 instance plus a HOLD_CYCLES=1 instance.
// Expected values follow DECODE_ACT_LOW_EN when the macro is defined.
module tb_decode_3_8_hold;

  logic       clk;
  logic       rst;
  logic [2:0] in_1;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_1;
  logic       out_valid;
  logic       busy;

  logic [2:0] h1_in;
  logic       h1_valid;
  logic       h1_ready;
  logic [7:0] h1_out;
  logic       h1_out_valid;
  logic       h1_busy;

  int checks;
  int errors;

  decode_3_8_hold #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_1(in_1), .in_valid(in_valid), .in_ready(in_ready),
    .out_1(out_1), .out_valid(out_valid), .busy(busy)
  );

  decode_3_8_hold #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_1(h1_in), .in_valid(h1_valid), .in_ready(h1_ready),
    .out_1(h1_out), .out_valid(h1_out_valid), .busy(h1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pol(input logic [7:0] hi);
`ifdef DECODE_ACT_LOW_EN
    return ~hi;
`else
    return hi;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_1 = 3'd0; h1_valid = 1'b0; h1_in = 3'd0;
    #12;
    checks++; if (out_1 !== pol(8'h00)) begin errors++; $display("FAIL reset_out got=%h exp=%h", out_1, pol(8'h00)); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", in_ready); end
    checks++; if (h1_ready !== 1'b1) begin errors++; $display("FAIL release_ready_h1 got=%b exp=1", h1_ready); end
  endtask

  task automatic test_single();
    in_1 = 3'd5; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; in_1 = 3'd2;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_1 !== pol(8'h20)) begin errors++; $display("FAIL single_out c%0d got=%h exp=%h", k, out_1, pol(8'h20)); end
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_valid c%0d got=%b/%b exp=1/1", k, out_valid, busy); end
      checks++; if (in_ready !== (k == 3)) begin errors++; $display("FAIL single_ready c%0d got=%b exp=%b", k, in_ready, k == 3); end
      cyc();
    end
    checks++; if (out_1 !== pol(8'h00)) begin errors++; $display("FAIL single_idle_out got=%h exp=%h", out_1, pol(8'h00)); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle_valid got=%b/%b exp=0/0", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    in_1 = 3'd0; in_valid = 1'b1;
    cyc();
    in_1 = 3'd7;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_1 !== pol(8'h01) || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first c%0d got=%h/%b exp=%h/1", k, out_1, out_valid, pol(8'h01)); end
      checks++; if (in_ready !== (k == 3)) begin errors++; $display("FAIL b2b_ready c%0d got=%b exp=%b", k, in_ready, k == 3); end
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_1 !== pol(8'h80) || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second c%0d got=%h/%b exp=%h/1", k, out_1, out_valid, pol(8'h80)); end
      checks++; if (in_ready !== (k == 3)) begin errors++; $display("FAIL b2b_ready2 c%0d got=%b exp=%b", k, in_ready, k == 3); end
      cyc();
    end
    checks++; if (out_1 !== pol(8'h00) || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%h/%b exp=%h/0", out_1, out_valid, pol(8'h00)); end
  endtask

  task automatic test_backpressure();
    in_1 = 3'd1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    checks++; if (out_1 !== pol(8'h02)) begin errors++; $display("FAIL bp_c0 got=%h exp=%h", out_1, pol(8'h02)); end
    cyc();
    in_1 = 3'd3; in_valid = 1'b1;
    checks++; if (out_1 !== pol(8'h02) || in_ready !== 1'b0) begin errors++; $display("FAIL bp_c1 got=%h/%b exp=%h/0", out_1, in_ready, pol(8'h02)); end
    cyc();
    checks++; if (out_1 !== pol(8'h02) || in_ready !== 1'b0) begin errors++; $display("FAIL bp_c2 got=%h/%b exp=%h/0", out_1, in_ready, pol(8'h02)); end
    cyc();
    checks++; if (out_1 !== pol(8'h02) || in_ready !== 1'b1) begin errors++; $display("FAIL bp_c3 got=%h/%b exp=%h/1", out_1, in_ready, pol(8'h02)); end
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_1 !== pol(8'h08) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_new c%0d got=%h/%b exp=%h/1", k, out_1, out_valid, pol(8'h08)); end
      cyc();
    end
    checks++; if (out_1 !== pol(8'h00) || out_valid !== 1'b0) begin errors++; $display("FAIL bp_once got=%h/%b exp=%h/0", out_1, out_valid, pol(8'h00)); end
  endtask

  task automatic test_hold1();
    logic [7:0] exp_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    h1_in = 3'd0; h1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      checks++; if (h1_out !== pol(exp_tab[k]) || h1_out_valid !== 1'b1) begin errors++; $display("FAIL h1_sweep k=%0d got=%h/%b exp=%h/1", k, h1_out, h1_out_valid, pol(exp_tab[k])); end
      checks++; if (h1_ready !== 1'b1) begin errors++; $display("FAIL h1_ready k=%0d got=%b exp=1", k, h1_ready); end
      h1_in = 3'(k + 1);
    end
    h1_valid = 1'b0;
    cyc();
    checks++; if (h1_out !== pol(8'h00) || h1_out_valid !== 1'b0 || h1_ready !== 1'b1) begin errors++; $display("FAIL h1_idle got=%h/%b/%b exp=%h/0/1", h1_out, h1_out_valid, h1_ready, pol(8'h00)); end
  endtask

  task automatic test_reset_mid_hold();
    in_1 = 3'd5; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    checks++; if (out_1 !== pol(8'h20) || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got=%h/%b exp=%h/1", out_1, busy, pol(8'h20)); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_1 !== pol(8'h00)) begin errors++; $display("FAIL mid_rst_out got=%h exp=%h", out_1, pol(8'h00)); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got=%b/%b/%b exp=0/0/0", out_valid, in_ready, busy); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_1 !== pol(8'h00)) begin errors++; $display("FAIL mid_release got=%b/%b/%h exp=1/0/%h", in_ready, out_valid, out_1, pol(8'h00)); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_hold1();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_3_8_hold.md
Name: decode_3_8_hold

Overview:
- Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time.
- Accepts a binary code and drives the matching one-hot line for HOLD_CYCLES clock cycles.
- Sits downstream of the priority encoder path: its output drives LED/strobe lines, or feeds the code back as a one-hot request vector.
- Back-to-back codes are accepted without a bubble.

Parameters:
- DATA_LEN, 3: code width. Output width is 2**DATA_LEN.
- OUT_LEN, 1<<DATA_LEN: one-hot output width. Derived; must not be overridden.
- HOLD_CYCLES, 4: cycles each decoded one-hot value is held valid. Legal range 1..255.
- CNT_W, 8: hold-counter width. Must satisfy 2**CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_1  input  DATA_LEN  binary code to decode
- in_valid  input  1  in_1 is valid this cycle
- in_ready  output  1  block can accept a code this cycle
- out_1  output  OUT_LEN  registered one-hot decode of the last accepted code; all-zero when idle
- out_valid  output  1  out_1 holds a valid decode
- busy  output  1  state is HOLD

Behaviour:
- Reset:
  - rst is asynchronous and active-high.
  - While asserted: state=IDLE, cnt=0, out_1=0, out_valid=0, busy=0, in_ready=0.
  - in_ready rises in the first cycle after rst deasserts.
- Accept: transfer occurs on a rising edge where in_valid & in_ready.
- in_ready rule:
  - in_ready = (state==IDLE) | (state==HOLD & cnt==HOLD_CYCLES-1).
  - Depends only on registered state, never on in_valid.
- States:
  - IDLE: out_valid=0, out_1=0.
    - On accept: go to HOLD, cnt<=0, out_1<=1<<in_1, out_valid<=1.
  - HOLD: out_valid=1, out_1 stable.
    - If cnt<HOLD_CYCLES-1: cnt<=cnt+1.
    - If cnt==HOLD_CYCLES-1 and accept: reload out_1<=1<<in_1 and cnt<=0; stay in HOLD. No gap between codes.
    - If cnt==HOLD_CYCLES-1 and no accept: go to IDLE, out_1<=0, out_valid<=0.
- Latency: out_1/out_valid update on the same edge that accepts; visible the cycle after in_valid is sampled.
- Hold length: each accepted code is visible for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: in_ready is permanently 1 after reset. Behaves as a plain registered decoder with valid.
- Input rules:
  - in_1 is ignored whenever no accept occurs.
  - A new in_valid during a non-final HOLD cycle is not accepted. The source must hold in_1/in_valid until in_ready.
- Output invariant: out_1 is exactly one-hot when out_valid=1 and exactly zero when out_valid=0. No other values are legal.
- Reset mid-HOLD: immediate asynchronous return to the reset values above. The interrupted code is dropped.
- Counter: cnt never exceeds HOLD_CYCLES-1 and never wraps.

Optional Feature:
- Macro: DECODE_ACT_LOW_EN.
- Defined:
  - out_1 is one-cold (active-low): idle and reset value is all-ones; the active line is the single 0 bit.
  - Accepting code k sets out_1 = ~(1<<k).
  - Handshake, timing and the other ports are unchanged.
- Undefined: active-high one-hot as specified above.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while in HOLD with out_1=8'h20 -> out_1=8'h00, out_valid=0, in_ready=0 immediately; in_ready=1 on the first cycle after release.
- Single code: HOLD_CYCLES=4, present in_1=3'd5 with in_valid for 1 cycle -> out_1=8'h20 with out_valid=1 for exactly 4 cycles, then 8'h00 and out_valid=0; busy tracks out_valid.
- Back-to-back: in_valid held high with in_1=3'd0, then 3'd7 once accepted -> out_1=8'h01 for 4 cycles, then 8'h80 for 4 cycles, with no idle cycle between; in_ready high only on cycles 4 and 8.
- Backpressure: in_valid=1 with in_1=3'd3 during HOLD cycle 2 of a code 3'd1 -> out_1 stays 8'h02 until the hold ends, then 8'h08; code 3 is accepted exactly once.
- HOLD_CYCLES=1, sweep in_1 0..7 with continuous in_valid -> out_1 = 01,02,04,...,80, one per cycle; in_ready constantly 1.
- With DECODE_ACT_LOW_EN defined, in_1=3'd2 -> out_1=8'hFB for 4 cycles; reset and idle value 8'hFF.
